// File: rtl/branch_resolve_pipe_pkg.sv
// Shared encodings for the branch resolution pipeline: op kinds, branch
// conditions and the target alignment masks.
package branch_resolve_pipe_pkg;

   localparam logic [1:0] KIND_BRANCH = 2'b00;
   localparam logic [1:0] KIND_JAL    = 2'b01;
   localparam logic [1:0] KIND_JALR   = 2'b10;
   localparam logic [1:0] KIND_RSVD   = 2'b11;

   localparam logic [2:0] F3_BEQ   = 3'b000;
   localparam logic [2:0] F3_BNE   = 3'b001;
   localparam logic [2:0] F3_RSVD2 = 3'b010;
   localparam logic [2:0] F3_RSVD3 = 3'b011;
   localparam logic [2:0] F3_BLT   = 3'b100;
   localparam logic [2:0] F3_BGE   = 3'b101;
   localparam logic [2:0] F3_BLTU  = 3'b110;
   localparam logic [2:0] F3_BGEU  = 3'b111;

   // Bits of target[1:0] that must be zero for a taken transfer.
   localparam logic [1:0] ALIGN_MASK_W4 = 2'b10;
   localparam logic [1:0] ALIGN_MASK_C  = 2'b00;

   function automatic logic isReservedF3(input logic [2:0] funct3);
      return (funct3 == F3_RSVD2) || (funct3 == F3_RSVD3);
   endfunction

endpackage

// File: rtl/branch_resolve_pipe_cmp.sv
// Combinational operand comparator: equality plus signed or unsigned
// less-than, selected by brUn.
module branch_cmp_core #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] dataA,
   input  logic [XLEN-1:0] dataB,
   input  logic            brUn,
   output logic            brEq,
   output logic            brLt
);

   assign brEq = (dataA == dataB);
   assign brLt = brUn ? (dataA < dataB) : ($signed(dataA) < $signed(dataB));

endmodule

// File: rtl/branch_resolve_pipe.sv
// Pipelined branch/jump resolution unit with valid/ready handshake and a
// saturating misprediction counter. STAGES selects 1- or 2-cycle latency.
module branch_resolve_pipe
   import branch_resolve_pipe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int STAGES  = 1,
   parameter int CNT_W   = 16,
   parameter int ALLOW_C = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [2:0]        in_funct3,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_pred_taken,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_taken,
   output logic [ADDR_W-1:0] out_target,
   output logic [ADDR_W-1:0] out_link,
   output logic              out_mispredict,
   output logic              out_misalign,
   output logic              out_illegal,
   output logic              out_br_eq,
   output logic              out_br_lt,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   localparam logic [1:0] ALIGN_MASK = (ALLOW_C != 0) ? ALIGN_MASK_C : ALIGN_MASK_W4;

   // Handshake: a beat moves when valid && ready on the same rising edge;
   // valid never waits on ready, and a held output stays stable until taken.
   // Flush empties every stage and overrides any simultaneous transfer.
   logic              outAdvance, accept, stageReady;
   logic              cmpEq, cmpLt;
   logic [XLEN-1:0]   jalrSum;
   logic [ADDR_W-1:0] brTarget, jalrTarget, linkAddr;

   logic              s1Valid, s1Eq, s1Lt, s1Pred;
   logic [1:0]        s1Kind;
   logic [2:0]        s1Funct3;
   logic [ADDR_W-1:0] s1BrTarget, s1JalrTarget, s1Link;

   logic              dIllegal, dTaken, dMisalign, dMispredict;
   logic [ADDR_W-1:0] dTarget;
   logic              delivered;

   branch_cmp_core #(.XLEN(XLEN)) uCmp (
      .dataA (in_rs1),
      .dataB (in_rs2),
      .brUn  (in_funct3[1]),
      .brEq  (cmpEq),
      .brLt  (cmpLt)
   );

   assign brTarget   = in_pc + in_imm[ADDR_W-1:0];
   assign jalrSum    = in_rs1 + in_imm;
   assign jalrTarget = {jalrSum[ADDR_W-1:1], 1'b0};
   assign linkAddr   = in_pc + ADDR_W'(4);

   assign outAdvance = !out_valid || out_ready;
   assign accept     = in_valid && in_ready && !flush;
   assign in_ready   = !rst && (flush || stageReady);

   generate
      if (STAGES == 2) begin : gTwoStage
         assign stageReady = !s1Valid || outAdvance;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1Valid      <= 1'b0;
               s1Eq         <= 1'b0;
               s1Lt         <= 1'b0;
               s1Pred       <= 1'b0;
               s1Kind       <= '0;
               s1Funct3     <= '0;
               s1BrTarget   <= '0;
               s1JalrTarget <= '0;
               s1Link       <= '0;
            end else if (flush) begin
               s1Valid <= 1'b0;
            end else if (stageReady) begin
               s1Valid <= accept;
               if (accept) begin
                  s1Eq         <= cmpEq;
                  s1Lt         <= cmpLt;
                  s1Pred       <= in_pred_taken;
                  s1Kind       <= in_kind;
                  s1Funct3     <= in_funct3;
                  s1BrTarget   <= brTarget;
                  s1JalrTarget <= jalrTarget;
                  s1Link       <= linkAddr;
               end
            end
         end
      end else begin : gOneStage
         assign stageReady   = outAdvance;
         assign s1Valid      = accept;
         assign s1Eq         = cmpEq;
         assign s1Lt         = cmpLt;
         assign s1Pred       = in_pred_taken;
         assign s1Kind       = in_kind;
         assign s1Funct3     = in_funct3;
         assign s1BrTarget   = brTarget;
         assign s1JalrTarget = jalrTarget;
         assign s1Link       = linkAddr;
      end
   endgenerate

   always_comb begin
      dIllegal = (s1Kind == KIND_RSVD) || ((s1Kind == KIND_BRANCH) && isReservedF3(s1Funct3));
      dTaken   = 1'b0;
      case (s1Kind)
         KIND_BRANCH: begin
            case (s1Funct3)
               F3_BEQ:  dTaken = s1Eq;
               F3_BNE:  dTaken = !s1Eq;
               F3_BLT:  dTaken = s1Lt;
               F3_BGE:  dTaken = !s1Lt;
               F3_BLTU: dTaken = s1Lt;
               F3_BGEU: dTaken = !s1Lt;
               default: dTaken = 1'b0;
            endcase
         end
         KIND_JAL, KIND_JALR: dTaken = 1'b1;
         default:             dTaken = 1'b0;
      endcase
      if (dIllegal) dTaken = 1'b0;
      dTarget     = (s1Kind == KIND_JALR) ? s1JalrTarget : s1BrTarget;
      dMisalign   = dTaken && ((dTarget[1:0] & ALIGN_MASK) != 2'b00);
      dMispredict = !dIllegal && (dTaken ^ s1Pred);
   end

   // Link is pc+4 for every kind; consumers only use it for JAL/JALR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_taken      <= 1'b0;
         out_target     <= '0;
         out_link       <= '0;
         out_mispredict <= 1'b0;
         out_misalign   <= 1'b0;
         out_illegal    <= 1'b0;
         out_br_eq      <= 1'b0;
         out_br_lt      <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (outAdvance) begin
         out_valid <= s1Valid;
         if (s1Valid) begin
            out_taken      <= dTaken;
            out_target     <= dTarget;
            out_link       <= s1Link;
            out_mispredict <= dMispredict;
            out_misalign   <= dMisalign;
            out_illegal    <= dIllegal;
            out_br_eq      <= s1Eq;
            out_br_lt      <= s1Lt;
         end
      end
   end

   assign delivered = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_cnt <= '0;
      end else if (cnt_clr) begin
         mispredict_cnt <= '0;
      end else if (delivered && out_mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
         mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
   end

endmodule
